mult_dotp_acc: RTL



---
 rtl/mult_dotp_acc.sv | 104 ++++++++++
 1 files changed

// File: rtl/mult_dotp_acc.sv
// Streaming dot-product accumulator for unsigned multiplier products, with a valid/ready result port.
// Define ACC_SAT_EN to clamp the sum on overflow; by default the sum wraps modulo 2^ACC_W.
module mult_dotp_acc #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [7:0]        out_count,
  output logic              out_ovf
);

  localparam logic [0:0] S_ACC  = 1'b0;
  localparam logic [0:0] S_DONE = 1'b1;
  localparam int         EXT_W  = ACC_W + 1 - PROD_W;
  localparam logic [7:0] LEN_B  = 8'(LEN);

  logic [0:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_count;
  logic             r_ovf;
  logic [ACC_W-1:0] r_out_sum;
  logic [7:0]       r_out_count;
  logic             r_out_ovf;

  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_next;
  logic [7:0]       w_count_inc;
  logic             w_ovf_next;
  logic             w_accept;
  logic             w_final;

  assign in_ready    = (r_state == S_ACC) && !clr;
  assign out_valid   = (r_state == S_DONE);
  assign out_sum     = r_out_sum;
  assign out_count   = r_out_count;
  assign out_ovf     = r_out_ovf;

  assign w_sum       = {1'b0, r_acc} + {{EXT_W{1'b0}}, in_prod};
  assign w_carry     = w_sum[ACC_W];
  assign w_ovf_next  = r_ovf | w_carry;
  assign w_count_inc = r_count + 8'd1;
  assign w_accept    = in_valid && in_ready;
  assign w_final     = in_last || (w_count_inc == LEN_B);

  // Once saturated, the sum stays pinned at full scale for the rest of the vector.
  always_comb begin
    w_acc_next = w_sum[ACC_W-1:0];
`ifdef ACC_SAT_EN
    if (w_carry || r_ovf) begin
      w_acc_next = '1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ACC;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (clr) begin
      r_state     <= S_ACC;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (r_state == S_ACC) begin
      if (w_accept) begin
        r_acc   <= w_acc_next;
        r_count <= w_count_inc;
        r_ovf   <= w_ovf_next;
        if (w_final) begin
          r_state     <= S_DONE;
          r_out_sum   <= w_acc_next;
          r_out_count <= w_count_inc;
          r_out_ovf   <= w_ovf_next;
        end
      end
    end else if (out_ready) begin
      // Result stays on out_* after the handshake; only the working sum is cleared.
      r_state <= S_ACC;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end
  end

endmodule
